lzrw1_group_packer: RTL and testbench

Packs the LZRW1 compressor's per-step results (literal byte or copy {length, offset}) into the final LZRW1 byte stream. Items are buffered into groups of GROUP_ITEMS. Each group is emitted as its control word, followed by the item bytes, on a byte-wide valid/ready stream. The block sits between the match comparator/hash-table stage and the output memory or DMA writer. It is a streaming, parametrised successor to the flat array-based compressed-value store.

---
 rtl/lzrw1_group_packer_if.sv | 36 +++
 rtl/lzrw1_group_packer.sv | 204 ++++++++++++++++++++
 tb/tb_lzrw1_group_packer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzrw1_group_packer_if.sv
// ---------------------------------------------------------------------------
// lzrw1_group_packer_if
// Item-in / byte-out stream bundle for the LZRW1 group packer.
//   in_valid/in_ready   : item handshake (producer -> packer)
//   in_copy             : 1 = copy item, 0 = literal
//   in_literal          : literal byte (in_copy=0)
//   in_length/in_offset : copy fields (in_copy=1)
//   in_last             : final item of the block, closes the group
//   out_valid/out_ready : packed byte handshake (packer -> consumer)
//   out_byte            : packed stream byte
//   out_last            : final byte of a group closed by in_last
// Modports: master = item producer / byte consumer, slave = packer.
// ---------------------------------------------------------------------------
interface lzrw1_group_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_copy;
  logic [7:0]  in_literal;
  logic [3:0]  in_length;
  logic [11:0] in_offset;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  modport master (
    output in_valid, in_copy, in_literal, in_length, in_offset, in_last, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_copy, in_literal, in_length, in_offset, in_last, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/lzrw1_group_packer.sv
// ---------------------------------------------------------------------------
// lzrw1_group_packer
// Buffers LZRW1 compressor items (literal byte or copy {length, offset}) into
// groups of GROUP_ITEMS and emits each group as its little-endian control
// word followed by the item bytes on a byte-wide valid/ready stream.
// Fill and drain never overlap: in_ready is low while a group is emitted.
//
// Parameters:
//   GROUP_ITEMS : items per group, multiple of 8 in 8..32
//   CTRL_BYTES  : derived control-word bytes per group
// Ports:
//   clock       : clock, posedge
//   reset       : synchronous, active-high
//   bus         : lzrw1_group_packer_if.slave item/byte streams
//   stat_bytes  : (LZRW1_PACKER_STATS_EN) output byte handshakes, wraps
//   stat_groups : (LZRW1_PACKER_STATS_EN) completed groups, wraps
// Optional feature macro: LZRW1_PACKER_STATS_EN (statistics counters).
// ---------------------------------------------------------------------------
module lzrw1_group_packer #(
  parameter  int GROUP_ITEMS = 16,
  localparam int CTRL_BYTES  = GROUP_ITEMS / 8
) (
  input  logic                   clock,
  input  logic                   reset,
  lzrw1_group_packer_if.slave    bus
`ifdef LZRW1_PACKER_STATS_EN
  ,
  output logic [31:0]            stat_bytes,
  output logic [15:0]            stat_groups
`endif
);

  localparam int IW = $clog2(GROUP_ITEMS + 1);
  localparam int BW = $clog2(2 * GROUP_ITEMS + 1);
  localparam int PW = $clog2(GROUP_ITEMS);
  localparam int CW = (CTRL_BYTES > 1) ? $clog2(CTRL_BYTES) : 1;

  typedef enum logic [1:0] {FILL, EMIT_CTRL, EMIT_DATA} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_item_cnt;
  logic [BW-1:0]          r_byte_cnt;
  logic [BW-1:0]          r_left;       // data bytes still to hand over, incl. the one on out_byte
  logic [GROUP_ITEMS-1:0] r_ctrl;
  logic                   r_last_flag;
  logic [CW-1:0]          r_ctrl_idx;
  logic [PW-1:0]          r_rd_ptr;
  logic                   r_half;       // second (offset low) byte of a copy is on out_byte
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [7:0]             r_out_byte;

  // Entry: {copy, length[3:0], offset_or_literal[15:0]}
  logic [20:0]            r_buf [GROUP_ITEMS];

  logic                   w_acc;
  logic                   w_close;
  logic                   w_out_hs;
  logic [GROUP_ITEMS-1:0] w_ctrl_nxt;
  logic [BW-1:0]          w_byte_cnt_nxt;
  logic [CW-1:0]          w_ctrl_idx_nxt;
  logic [7:0]             w_ctrl_byte;
  logic [PW-1:0]          w_nxt_ptr;
  logic [20:0]            w_cur;
  logic [20:0]            w_nxt;
  logic [20:0]            w_head;
  logic                   w_unused_bits;

  function automatic logic [7:0] first_byte(input logic copy, input logic [3:0] len,
                                            input logic [11:0] low);
    return copy ? {len, low[11:8]} : low[7:0];
  endfunction

  assign w_acc          = bus.in_valid && r_in_ready;
  assign w_close        = bus.in_last || (r_item_cnt == IW'(GROUP_ITEMS - 1));
  assign w_out_hs       = r_out_valid && bus.out_ready;
  assign w_ctrl_nxt     = r_ctrl | ({{(GROUP_ITEMS-1){1'b0}}, bus.in_copy} << r_item_cnt);
  assign w_byte_cnt_nxt = r_byte_cnt + (bus.in_copy ? BW'(2) : BW'(1));
  assign w_ctrl_idx_nxt = r_ctrl_idx + CW'(1);
  assign w_nxt_ptr      = r_rd_ptr + PW'(1);
  assign w_cur          = r_buf[r_rd_ptr];
  assign w_nxt          = r_buf[w_nxt_ptr];
  assign w_head         = r_buf[0];
  // Literal entries keep bits [15:8] zero and copies keep [15:12] zero.
  assign w_unused_bits  = ^{w_cur[19:8], w_nxt[15:12], w_head[15:12]};

  always_comb begin
    w_ctrl_byte = '0;
    for (int k = 0; k < CTRL_BYTES; k++) begin
      if (CW'(k) == w_ctrl_idx_nxt) w_ctrl_byte = r_ctrl[8*k +: 8];
    end
  end

  // Item store: data only, no reset; stale entries are never read back.
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_buf[r_item_cnt[PW-1:0]] <= {bus.in_copy, bus.in_length,
                                    bus.in_copy ? {4'h0, bus.in_offset} : {8'h00, bus.in_literal}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= FILL;
      r_item_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_left      <= '0;
      r_ctrl      <= '0;
      r_last_flag <= 1'b0;
      r_ctrl_idx  <= '0;
      r_rd_ptr    <= '0;
      r_half      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_byte  <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_acc) begin
            r_ctrl     <= w_ctrl_nxt;
            r_item_cnt <= r_item_cnt + IW'(1);
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_close) begin
              // Closing item's control bit is folded in before the first control byte goes out.
              r_state     <= EMIT_CTRL;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_byte  <= w_ctrl_nxt[7:0];
              r_out_last  <= 1'b0;
              r_ctrl_idx  <= '0;
              r_last_flag <= bus.in_last;
            end
          end
        end

        EMIT_CTRL: begin
          if (bus.out_ready) begin
            if (r_ctrl_idx == CW'(CTRL_BYTES - 1)) begin
              r_state    <= EMIT_DATA;
              r_rd_ptr   <= '0;
              r_half     <= 1'b0;
              r_left     <= r_byte_cnt;
              r_out_byte <= first_byte(w_head[20], w_head[19:16], w_head[11:0]);
              r_out_last <= r_last_flag && (r_byte_cnt == BW'(1));
            end else begin
              r_ctrl_idx <= w_ctrl_idx_nxt;
              r_out_byte <= w_ctrl_byte;
            end
          end
        end

        EMIT_DATA: begin
          if (bus.out_ready) begin
            r_left <= r_left - BW'(1);
            if (r_left == BW'(1)) begin
              r_state     <= FILL;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_byte  <= '0;
              r_item_cnt  <= '0;
              r_byte_cnt  <= '0;
              r_ctrl      <= '0;
              r_last_flag <= 1'b0;
            end else begin
              r_out_last <= r_last_flag && (r_left == BW'(2));
              if (w_cur[20] && !r_half) begin
                r_half     <= 1'b1;
                r_out_byte <= w_cur[7:0];
              end else begin
                r_half     <= 1'b0;
                r_rd_ptr   <= w_nxt_ptr;
                r_out_byte <= first_byte(w_nxt[20], w_nxt[19:16], w_nxt[11:0]);
              end
            end
          end
        end

        default: r_state <= FILL;
      endcase
    end
  end

`ifdef LZRW1_PACKER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_bytes  <= '0;
      stat_groups <= '0;
    end else begin
      if (w_out_hs) stat_bytes <= stat_bytes + 32'd1;
      if (w_out_hs && (r_state == EMIT_DATA) && (r_left == BW'(1)))
        stat_groups <= stat_groups + 16'd1;
    end
  end
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_byte  = r_out_byte;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_lzrw1_group_packer.sv
module tb_lzrw1_group_packer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lzrw1_group_packer_if bus_a ();
  lzrw1_group_packer_if bus_b ();

`ifdef LZRW1_PACKER_STATS_EN
  logic [31:0] sb_a, sb_b;
  logic [15:0] sg_a, sg_b;
`endif

  lzrw1_group_packer #(.GROUP_ITEMS(16)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
`ifdef LZRW1_PACKER_STATS_EN
    ,
    .stat_bytes  (sb_a),
    .stat_groups (sg_a)
`endif
  );

  lzrw1_group_packer #(.GROUP_ITEMS(8)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
`ifdef LZRW1_PACKER_STATS_EN
    ,
    .stat_bytes  (sb_b),
    .stat_groups (sg_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  int hs_a  = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pa(input logic last, input logic [7:0] b);
    qa.push_back({last, b});
  endtask

  task automatic pb(input logic last, input logic [7:0] b);
    qb.push_back({last, b});
  endtask

  // Scoreboard monitor for the 16-item packer, with stall-stability check.
  logic       stall_a;
  logic [8:0] held_a;
  logic [8:0] ea;
  always @(negedge clock) begin
    if (reset) begin
      stall_a <= 1'b0;
    end else begin
      if (stall_a && bus_a.out_valid)
        check("hold_a", {23'b0, bus_a.out_last, bus_a.out_byte}, {23'b0, held_a});
      if (bus_a.out_valid && bus_a.out_ready) begin
        hs_a++;
        total++;
        if (qa.size() == 0) begin
          bad++;
          $display("FAIL extra_a: got byte 0x%0h expected no byte", bus_a.out_byte);
        end else begin
          ea = qa.pop_front();
          if ({bus_a.out_last, bus_a.out_byte} !== ea) begin
            bad++;
            $display("FAIL byte_a: got last=%0b byte=0x%0h expected last=%0b byte=0x%0h",
                     bus_a.out_last, bus_a.out_byte, ea[8], ea[7:0]);
          end
        end
      end
      stall_a <= bus_a.out_valid && !bus_a.out_ready;
      held_a  <= {bus_a.out_last, bus_a.out_byte};
    end
  end

  // Scoreboard monitor for the 8-item packer.
  logic [8:0] eb;
  always @(negedge clock) begin
    if (!reset && bus_b.out_valid && bus_b.out_ready) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL extra_b: got byte 0x%0h expected no byte", bus_b.out_byte);
      end else begin
        eb = qb.pop_front();
        if ({bus_b.out_last, bus_b.out_byte} !== eb) begin
          bad++;
          $display("FAIL byte_b: got last=%0b byte=0x%0h expected last=%0b byte=0x%0h",
                   bus_b.out_last, bus_b.out_byte, eb[8], eb[7:0]);
        end
      end
    end
  end

  task automatic send_a(input logic c, input logic [7:0] lit, input logic [3:0] len,
                        input logic [11:0] off, input logic last);
    int  n   = 0;
    logic acc = 1'b0;
    bus_a.in_valid   = 1'b1;
    bus_a.in_copy    = c;
    bus_a.in_literal = lit;
    bus_a.in_length  = len;
    bus_a.in_offset  = off;
    bus_a.in_last    = last;
    while (!acc) begin
      @(negedge clock);
      acc = bus_a.in_ready;
      @(posedge clock);
      #1;
      n++;
      if (!acc && n > 200) begin
        total++; bad++;
        $display("FAIL send_a: in_ready stayed 0 for %0d cycles, required 1", n);
        acc = 1'b1;
      end
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] lit);
    int  n   = 0;
    logic acc = 1'b0;
    bus_b.in_valid   = 1'b1;
    bus_b.in_copy    = 1'b0;
    bus_b.in_literal = lit;
    while (!acc) begin
      @(negedge clock);
      acc = bus_b.in_ready;
      @(posedge clock);
      #1;
      n++;
      if (!acc && n > 200) begin
        total++; bad++;
        $display("FAIL send_b: in_ready stayed 0 for %0d cycles, required 1", n);
        acc = 1'b1;
      end
    end
    bus_b.in_valid = 1'b0;
  endtask

  // Wait until the 16-item packer has drained its group; optional random out_ready.
  task automatic drain_a(input string nm, input logic rnd);
    int n = 0;
    while (n < 1000) begin
      @(negedge clock);
      if (qa.size() == 0 && bus_a.in_ready) break;
      @(posedge clock);
      #1;
      if (rnd) bus_a.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus_a.out_ready = 1'b1;
    check({"drain_", nm}, qa.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic drain_b(input string nm);
    int n = 0;
    while (n < 1000 && !(qb.size() == 0 && bus_b.in_ready)) begin
      @(negedge clock);
      n++;
    end
    check({"drain_", nm}, qb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_copy = 1'b0; bus_a.in_literal = '0;
    bus_a.in_length = '0;  bus_a.in_offset = '0; bus_a.in_last = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_copy = 1'b0; bus_b.in_literal = '0;
    bus_b.in_length = '0;  bus_b.in_offset = '0; bus_b.in_last = 1'b0;
    bus_b.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",  bus_a.in_ready,  1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_byte",  bus_a.out_byte,  0);
    check("rst_out_last",  bus_a.out_last,  0);
    @(posedge clock); #1;

    // 16 literals 0x00..0x0F: control 0x00,0x00 then the literals; group latency 19.
    pa(0, 8'h00); pa(0, 8'h00);
    for (int i = 0; i < 16; i++) pa(0, 8'(i));
    for (int i = 0; i < 16; i++) send_a(1'b0, 8'(i), 4'h0, 12'h000, 1'b0);
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      if (bus_a.in_ready) break;
    end
    check("latency_lit16", n, 19);
    @(posedge clock); #1;
    drain_a("lit16", 1'b0);

    // 16 copies len=3 off=0xABC: 0xFF,0xFF then 16 x (0x3A,0xBC), 34 bytes.
    hs0 = hs_a;
    pa(0, 8'hFF); pa(0, 8'hFF);
    for (int i = 0; i < 16; i++) begin pa(0, 8'h3A); pa(0, 8'hBC); end
    for (int i = 0; i < 16; i++) send_a(1'b1, 8'h00, 4'h3, 12'hABC, 1'b0);
    drain_a("copy16", 1'b0);
    check("count_copy16", hs_a - hs0, 34);

    // L,C,L,C,L with in_last on the fifth item.
    pa(0, 8'h0A); pa(0, 8'h00);
    pa(0, 8'h11); pa(0, 8'h20); pa(0, 8'h12);
    pa(0, 8'h22); pa(0, 8'h20); pa(0, 8'h12);
    pa(1, 8'h33);
    send_a(1'b0, 8'h11, 4'h0, 12'h000, 1'b0);
    send_a(1'b1, 8'h00, 4'h2, 12'h012, 1'b0);
    send_a(1'b0, 8'h22, 4'h0, 12'h000, 1'b0);
    send_a(1'b1, 8'h00, 4'h2, 12'h012, 1'b0);
    send_a(1'b0, 8'h33, 4'h0, 12'h000, 1'b1);
    drain_a("mixed_last", 1'b0);

    // Full literal group drained under random back-pressure.
    pa(0, 8'h00); pa(0, 8'h00);
    for (int i = 0; i < 16; i++) pa(0, 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) send_a(1'b0, 8'hA0 + 8'(i), 4'h0, 12'h000, 1'b0);
    drain_a("stall", 1'b1);

    // Reset in the middle of the data bytes of a copy group.
    pa(0, 8'hFF); pa(0, 8'hFF);
    for (int i = 0; i < 16; i++) begin pa(0, 8'h12); pa(0, 8'h34); end
    for (int i = 0; i < 16; i++) send_a(1'b1, 8'h00, 4'h1, 12'h234, 1'b0);
    repeat (6) @(posedge clock);
    #1;
    bus_a.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_out_valid", bus_a.out_valid, 0);
    check("abort_in_ready",  bus_a.in_ready,  1);
    check("abort_out_last",  bus_a.out_last,  0);
    qa.delete();
    @(posedge clock); #1;
    bus_a.out_ready = 1'b1;
    pa(0, 8'h00); pa(0, 8'h00); pa(0, 8'h77); pa(1, 8'h78);
    send_a(1'b0, 8'h77, 4'h0, 12'h000, 1'b0);
    send_a(1'b0, 8'h78, 4'h0, 12'h000, 1'b1);
    drain_a("post_reset", 1'b0);

    // GROUP_ITEMS=8: two literal groups, one control byte each.
    pb(0, 8'h00);
    for (int i = 0; i < 8; i++) pb(0, 8'(i));
    pb(0, 8'h00);
    for (int i = 8; i < 16; i++) pb(0, 8'(i));
    for (int i = 0; i < 16; i++) send_b(8'(i));
    drain_b("g8");

`ifdef LZRW1_PACKER_STATS_EN
    check("stat_bytes_b",  sb_b, 18);
    check("stat_groups_b", {16'b0, sg_b}, 2);
    check("stat_bytes_a",  sb_a, 4);
    check("stat_groups_a", {16'b0, sg_a}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
